// File: rtl/event_flag_queue_pkg.sv
// event_flag_queue_pkg: shared defaults and FSM encoding for the event flag queue.
// Revision 1.0
`default_nettype none

package event_flag_queue_pkg;

  localparam int DEF_TAG_WIDTH  = 8;
  localparam int DEF_DEPTH_LOG2 = 2;
  localparam int DEF_DROP_WIDTH = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/event_flag_queue_fifo.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO, occupancy-based full/empty.
// Revision 1.0
`default_nettype none

module sync_fifo_fwft #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == COUNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/event_flag_queue.sv
// event_flag_queue: buffers tagged events and hands them one at a time to the flag synchronizer.
// Revision 1.0
`default_nettype none

module event_flag_queue
  import event_flag_queue_pkg::*;
#(
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DROP_WIDTH = DEF_DROP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  event_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  input  logic                  clr_ovf_i,
  input  logic                  sync_busy_i,
  output logic                  flag_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic [DEPTH_LOG2:0]   pending_o,
  output logic                  overflow_o,
  output logic [DROP_WIDTH-1:0] drop_cnt_o
);

  localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

  logic [1:0]           state;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [TAG_WIDTH-1:0] fifo_dout;
  logic                 push;
  logic                 pop;
  logic                 drop;

  // Fullness is judged before any same-cycle pop, so a pop never makes room for a concurrent push.
  assign push = event_i && !fifo_full;
  assign drop = event_i && fifo_full;
  assign pop  = (state == ST_IDLE) && !fifo_empty && !sync_busy_i;

  sync_fifo_fwft #(
    .WIDTH      (TAG_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (tag_i),
    .dout  (fifo_dout),
    .count (pending_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      flag_o <= 1'b0;
      tag_o  <= '0;
    end else begin
      flag_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tag_o  <= fifo_dout;
            flag_o <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_BUSY;
        end
        // Busy lags the flag by a cycle; waiting for its rise closes that gap.
        ST_WAIT_BUSY: begin
          if (sync_busy_i) begin
            state <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (!sync_busy_i) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (clr_ovf_i) begin
        drop_cnt_o <= DROP_WIDTH'(1);
      end else if (drop_cnt_o != DROP_MAX) begin
        drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end else if (clr_ovf_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_event_flag_queue.sv
// tb_event_flag_queue: directed stimulus with a queue-based reference model of the event flag queue.
// Revision 1.0
`default_nettype none

module tb_event_flag_queue;

  localparam int TW    = 8;
  localparam int DL    = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 4;
  localparam int DMAX  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          event_i = 1'b0;
  logic [TW-1:0] tag_i = '0;
  logic          clr_ovf_i = 1'b0;
  logic          force_busy = 1'b0;
  logic          sync_busy_i;
  logic          flag_o;
  logic [TW-1:0] tag_o;
  logic [DL:0]   pending_o;
  logic          overflow_o;
  logic [DW-1:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;
  int bcnt = 0;
  bit chk_on = 1'b0;
  bit prev_flag = 1'b0;
  logic [TW-1:0] got[$];

  event_flag_queue #(
    .TAG_WIDTH  (TW),
    .DEPTH_LOG2 (DL),
    .DROP_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .event_i     (event_i),
    .tag_i       (tag_i),
    .clr_ovf_i   (clr_ovf_i),
    .sync_busy_i (sync_busy_i),
    .flag_o      (flag_o),
    .tag_o       (tag_o),
    .pending_o   (pending_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Synchronizer stand-in: busy rises the cycle after a flag and lasts six cycles.
  assign sync_busy_i = force_busy | (bcnt != 0);
  always @(posedge clk) begin
    if (flag_o === 1'b1) bcnt <= 6;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end

  // Reference model: queue of waiting tags plus an in-flight handshake tracker.
  logic [TW-1:0] mq[$];
  bit            m_flag = 1'b0;
  bit            m_inflight = 1'b0;
  bit            m_risen = 1'b0;
  logic [TW-1:0] m_tag = '0;
  bit            m_ovf = 1'b0;
  int            m_drop = 0;

  always @(posedge clk) begin
    bit was_full;
    if (!rst_n) begin
      mq.delete();
      m_flag = 1'b0; m_inflight = 1'b0; m_risen = 1'b0;
      m_tag = '0; m_ovf = 1'b0; m_drop = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (event_i && was_full) begin
        m_ovf = 1'b1;
        m_drop = clr_ovf_i ? 1 : ((m_drop == DMAX) ? DMAX : m_drop + 1);
      end else if (clr_ovf_i) begin
        m_ovf = 1'b0;
        m_drop = 0;
      end
      if (m_flag) begin
        m_flag = 1'b0;
      end else if (m_inflight) begin
        if (!m_risen) begin
          if (sync_busy_i) m_risen = 1'b1;
        end else if (!sync_busy_i) begin
          m_inflight = 1'b0;
        end
      end else if (mq.size() > 0 && !sync_busy_i) begin
        m_tag = mq.pop_front();
        m_flag = 1'b1;
        m_inflight = 1'b1;
        m_risen = 1'b0;
      end
      if (event_i && !was_full) mq.push_back(tag_i);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("flag_o", int'(flag_o), int'(m_flag));
      chk("tag_o", int'(tag_o), int'(m_tag));
      chk("pending_o", int'(pending_o), mq.size());
      chk("overflow_o", int'(overflow_o), int'(m_ovf));
      chk("drop_cnt_o", int'(drop_cnt_o), m_drop);
      chk("flag_twice", int'(flag_o === 1'b1 && prev_flag), 0);
      if (flag_o === 1'b1 && rst_n) got.push_back(tag_o);
    end
    prev_flag = (flag_o === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      event_i = 1'b1;
      tag_i = TW'(base + i);
      cyc(1);
    end
    event_i = 1'b0;
  endtask

  task automatic wait_tags(input int n, input int maxc);
    int k = 0;
    while (got.size() < n && k < maxc) begin
      cyc(1);
      k++;
    end
    chk("wait_tags", got.size(), n);
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while ((m_inflight || mq.size() != 0 || bcnt != 0) && k < maxc) begin
      cyc(1);
      k++;
    end
    chk("wait_idle", int'(m_inflight || mq.size() != 0), 0);
  endtask

  initial begin
    cyc(1);
    chk_on = 1'b1;
    cyc(2);
    chk("rst_flag", int'(flag_o), 0);
    chk("rst_tag", int'(tag_o), 0);
    chk("rst_pending", int'(pending_o), 0);
    chk("rst_ovf", int'(overflow_o), 0);
    chk("rst_drop", int'(drop_cnt_o), 0);
    rst_n = 1'b1;
    cyc(5);

    // Single event with literal timing
    got.delete();
    event_i = 1'b1; tag_i = 8'hA5;
    cyc(1);
    event_i = 1'b0;
    chk("single_pend1", int'(pending_o), 1);
    chk("single_noflag", int'(flag_o), 0);
    cyc(1);
    chk("single_flag", int'(flag_o), 1);
    chk("single_tag", int'(tag_o), 8'hA5);
    chk("single_pend0", int'(pending_o), 0);
    cyc(1);
    chk("single_flag_low", int'(flag_o), 0);
    cyc(5);
    chk("single_hold", int'(tag_o), 8'hA5);
    wait_idle(50);
    chk("single_count", got.size(), 1);

    // Burst of four
    got.delete();
    burst(4, 1);
    wait_tags(4, 200);
    for (int i = 0; i < 4; i++) chk("burst_tag", (i < got.size()) ? int'(got[i]) : -1, i + 1);
    wait_idle(100);

    // Overflow with busy held
    force_busy = 1'b1;
    cyc(1);
    burst(6, 1);
    chk("ovf_pending", int'(pending_o), 4);
    chk("ovf_flag", int'(overflow_o), 1);
    chk("ovf_drop", int'(drop_cnt_o), 2);
    got.delete();
    force_busy = 1'b0;
    wait_tags(4, 200);
    for (int i = 0; i < 4; i++) chk("ovf_tag", (i < got.size()) ? int'(got[i]) : -1, i + 1);
    wait_idle(100);
    clr_ovf_i = 1'b1;
    cyc(1);
    clr_ovf_i = 1'b0;
    chk("clr_ovf", int'(overflow_o), 0);
    chk("clr_drop", int'(drop_cnt_o), 0);

    // Saturation, then clear coincident with a drop
    force_busy = 1'b1;
    cyc(1);
    burst(14, 8'h10);
    chk("sat_drop", int'(drop_cnt_o), 3);
    event_i = 1'b1; tag_i = 8'hCC; clr_ovf_i = 1'b1;
    cyc(1);
    event_i = 1'b0; clr_ovf_i = 1'b0;
    chk("clr_vs_drop_cnt", int'(drop_cnt_o), 1);
    chk("clr_vs_drop_ovf", int'(overflow_o), 1);

    // Pop and push on a full FIFO in the same cycle: the push is dropped
    force_busy = 1'b0; event_i = 1'b1; tag_i = 8'hEE;
    cyc(1);
    event_i = 1'b0;
    chk("fullpp_pending", int'(pending_o), 3);
    chk("fullpp_drop", int'(drop_cnt_o), 2);
    chk("fullpp_flag", int'(flag_o), 1);
    chk("fullpp_tag", int'(tag_o), 8'h10);
    wait_idle(300);

    // Reset while waiting for busy to fall with three queued
    got.delete();
    force_busy = 1'b1;
    cyc(1);
    burst(4, 8'h20);
    force_busy = 1'b0;
    wait_tags(1, 50);
    cyc(3);
    chk("mid_pending", int'(pending_o), 3);
    force_busy = 1'b1; rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_flag", int'(flag_o), 0);
    chk("mid_rst_tag", int'(tag_o), 0);
    chk("mid_rst_pending", int'(pending_o), 0);
    chk("mid_rst_ovf", int'(overflow_o), 0);
    chk("mid_rst_drop", int'(drop_cnt_o), 0);
    rst_n = 1'b1;
    event_i = 1'b1; tag_i = 8'h77;
    cyc(1);
    event_i = 1'b0;
    cyc(10);
    chk("busy_block_count", got.size(), 1);
    chk("busy_block_pend", int'(pending_o), 1);
    force_busy = 1'b0;
    wait_tags(2, 50);
    chk("post_rst_tag", (got.size() > 1) ? int'(got[1]) : -1, 8'h77);
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
